// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry holding buffer per execution unit, fixed priority
// div > mult > int/mem with an LRU bit between int and mem. Optional CDB_CONFLICT_CNT_EN adds conflict_cnt.
module cdb_arbiter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
`ifdef CDB_CONFLICT_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             int_valid,
    input  logic             mult_valid,
    input  logic             div_valid,
    input  logic             mem_valid,
    input  logic [TAG_W-1:0] int_tag,
    input  logic [TAG_W-1:0] mult_tag,
    input  logic [TAG_W-1:0] div_tag,
    input  logic [TAG_W-1:0] mem_tag,
    input  logic [XLEN-1:0]  int_data,
    input  logic [XLEN-1:0]  mult_data,
    input  logic [XLEN-1:0]  div_data,
    input  logic [XLEN-1:0]  mem_data,
    output logic             int_stall,
    output logic             mult_stall,
    output logic             div_stall,
    output logic             mem_stall,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_data,
    output logic [1:0]       cdb_src,
    output logic             cdb_overrun
`ifdef CDB_CONFLICT_CNT_EN
    ,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    localparam logic [1:0] SRC_INT  = 2'd0;
    localparam logic [1:0] SRC_MULT = 2'd1;
    localparam logic [1:0] SRC_DIV  = 2'd2;
    localparam logic [1:0] SRC_MEM  = 2'd3;

    logic [3:0]       src_valid;
    logic [TAG_W-1:0] src_tag   [4];
    logic [XLEN-1:0]  src_data  [4];

    logic [3:0]       buf_v;
    logic [TAG_W-1:0] buf_tag   [4];
    logic [XLEN-1:0]  buf_data  [4];

    logic [3:0]       cand;
    logic [TAG_W-1:0] cand_tag  [4];
    logic [XLEN-1:0]  cand_data [4];
    logic [3:0]       win_hot;
    logic [3:0]       load;
    logic [1:0]       win_idx;
    logic             any_cand;
    logic             lru;

    // Index order matches the cdb_src encoding.
    assign src_valid   = {mem_valid, div_valid, mult_valid, int_valid};
    assign src_tag[0]  = int_tag;
    assign src_tag[1]  = mult_tag;
    assign src_tag[2]  = div_tag;
    assign src_tag[3]  = mem_tag;
    assign src_data[0] = int_data;
    assign src_data[1] = mult_data;
    assign src_data[2] = div_data;
    assign src_data[3] = mem_data;

    assign int_stall  = buf_v[SRC_INT];
    assign mult_stall = buf_v[SRC_MULT];
    assign div_stall  = buf_v[SRC_DIV];
    assign mem_stall  = buf_v[SRC_MEM];

    assign any_cand = |cand;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_src
            // A buffered entry always shadows the live input; a live input under a full buffer is dropped.
            assign cand[gi]      = buf_v[gi] | src_valid[gi];
            assign cand_tag[gi]  = buf_v[gi] ? buf_tag[gi]  : src_tag[gi];
            assign cand_data[gi] = buf_v[gi] ? buf_data[gi] : src_data[gi];
            assign win_hot[gi]   = any_cand && (win_idx == 2'(gi));
            assign load[gi]      = src_valid[gi] && !buf_v[gi] && !win_hot[gi];
        end
    endgenerate

    always_comb begin
        win_idx = SRC_INT;
        if (cand[SRC_DIV])
            win_idx = SRC_DIV;
        else if (cand[SRC_MULT])
            win_idx = SRC_MULT;
        else if (cand[SRC_INT] && cand[SRC_MEM])
            win_idx = lru ? SRC_INT : SRC_MEM;
        else if (cand[SRC_MEM])
            win_idx = SRC_MEM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_v <= '0;
            for (int i = 0; i < 4; i++) begin
                buf_tag[i]  <= '0;
                buf_data[i] <= '0;
            end
        end else if (flush) begin
            buf_v <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    buf_v[i]    <= 1'b1;
                    buf_tag[i]  <= src_tag[i];
                    buf_data[i] <= src_data[i];
                end else if (win_hot[i]) begin
                    buf_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid   <= 1'b0;
            cdb_tag     <= '0;
            cdb_data    <= '0;
            cdb_src     <= SRC_INT;
            cdb_overrun <= 1'b0;
            lru         <= 1'b1;
        end else begin
            // Sticky regardless of flush: the unit broke the stall handshake either way.
            if (|(src_valid & buf_v))
                cdb_overrun <= 1'b1;
            if (flush) begin
                cdb_valid <= 1'b0;
                lru       <= 1'b1;
            end else begin
                cdb_valid <= any_cand;
                if (any_cand) begin
                    cdb_tag  <= cand_tag[win_idx];
                    cdb_data <= cand_data[win_idx];
                    cdb_src  <= win_idx;
                end
                if (win_hot[SRC_INT])
                    lru <= 1'b0;
                else if (win_hot[SRC_MEM])
                    lru <= 1'b1;
            end
        end
    end

`ifdef CDB_CONFLICT_CNT_EN
    logic multi_cand;

    // Clearing the lowest set bit leaves a nonzero value only when two or more bits were set.
    assign multi_cand = |(cand & (cand - 4'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conflict_cnt <= '0;
        else if (!flush && multi_cand && (conflict_cnt != {CNT_W{1'b1}}))
            conflict_cnt <= conflict_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a scoreboard holds the expected CDB order,
// per-scenario tasks check stalls, timing, overrun, flush and reset.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        int_valid, mult_valid, div_valid, mem_valid;
    logic [5:0]  int_tag, mult_tag, div_tag, mem_tag;
    logic [31:0] int_data, mult_data, div_data, mem_data;
    logic        int_stall, mult_stall, div_stall, mem_stall;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [1:0]  cdb_src;
    logic        cdb_overrun;
`ifdef CDB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
`endif

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
        logic [1:0]  src;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .int_valid  (int_valid),
        .mult_valid (mult_valid),
        .div_valid  (div_valid),
        .mem_valid  (mem_valid),
        .int_tag    (int_tag),
        .mult_tag   (mult_tag),
        .div_tag    (div_tag),
        .mem_tag    (mem_tag),
        .int_data   (int_data),
        .mult_data  (mult_data),
        .div_data   (div_data),
        .mem_data   (mem_data),
        .int_stall  (int_stall),
        .mult_stall (mult_stall),
        .div_stall  (div_stall),
        .mem_stall  (mem_stall),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .cdb_src    (cdb_src),
        .cdb_overrun(cdb_overrun)
`ifdef CDB_CONFLICT_CNT_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    // Scoreboard consumer: every broadcast must match the next expected result.
    always @(negedge clk) begin
        if (cdb_valid) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL cdb_unexpected got tag=%0d data=%h src=%0d, expected no broadcast",
                         cdb_tag, cdb_data, cdb_src);
            end else begin
                e = sb.pop_front();
                if ({cdb_tag, cdb_data, cdb_src} !== e) begin
                    errors++;
                    $display("FAIL cdb_result got tag=%0d data=%h src=%0d, expected tag=%0d data=%h src=%0d",
                             cdb_tag, cdb_data, cdb_src, e.tag, e.data, e.src);
                end else begin
                    $display("cdb tag=%0d data=%h src=%0d ok", cdb_tag, cdb_data, cdb_src);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        int_valid = 0; mult_valid = 0; div_valid = 0; mem_valid = 0;
        flush = 0;
    endtask

    task automatic drive(input logic [1:0] src, input logic [5:0] tag, input logic [31:0] data);
        case (src)
            2'd0: begin int_valid  = 1; int_tag  = tag; int_data  = data; end
            2'd1: begin mult_valid = 1; mult_tag = tag; mult_data = data; end
            2'd2: begin div_valid  = 1; div_tag  = tag; div_data  = data; end
            default: begin mem_valid = 1; mem_tag = tag; mem_data = data; end
        endcase
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src, cdb_overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b tag=%0d data=%h src=%0d ovr=%b, expected all zero",
                     cdb_valid, cdb_tag, cdb_data, cdb_src, cdb_overrun);
        end
        checks++;
        if ({int_stall, mult_stall, div_stall, mem_stall} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_stalls got %b%b%b%b, expected 0000", int_stall, mult_stall, div_stall, mem_stall);
        end
`ifdef CDB_CONFLICT_CNT_EN
        checks++;
        if (conflict_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_conflict_cnt got %0d, expected 0", conflict_cnt);
        end
`endif
        rst = 0;
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid got %b, expected 0", cdb_valid);
        end
    endtask

    task automatic test_single();
        drive(2'd0, 6'd5, 32'hA5);
        sb.push_back('{tag: 6'd5, data: 32'hA5, src: 2'd0});
        tick();
        idle_inputs();
        checks++;
        if (cdb_valid !== 1'b1 || {int_stall, mult_stall, div_stall, mem_stall} !== 4'b0000) begin
            errors++;
            $display("FAIL single_latency got valid=%b stalls=%b%b%b%b, expected valid=1 stalls=0000",
                     cdb_valid, int_stall, mult_stall, div_stall, mem_stall);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 6'd5 || cdb_data !== 32'hA5) begin
            errors++;
            $display("FAIL single_hold got valid=%b tag=%0d data=%h, expected valid=0 tag=5 data=a5",
                     cdb_valid, cdb_tag, cdb_data);
        end
    endtask

    task automatic test_div_mult();
        drive(2'd2, 6'd3, 32'h33);
        drive(2'd1, 6'd9, 32'h99);
        sb.push_back('{tag: 6'd3, data: 32'h33, src: 2'd2});
        sb.push_back('{tag: 6'd9, data: 32'h99, src: 2'd1});
        tick();
        idle_inputs();
        checks++;
        if (cdb_src !== 2'd2 || mult_stall !== 1'b1 || div_stall !== 1'b0) begin
            errors++;
            $display("FAIL div_mult_n1 got src=%0d mult_stall=%b div_stall=%b, expected src=2 mult_stall=1 div_stall=0",
                     cdb_src, mult_stall, div_stall);
        end
        tick();
        checks++;
        if (cdb_src !== 2'd1 || cdb_valid !== 1'b1 || mult_stall !== 1'b0) begin
            errors++;
            $display("FAIL div_mult_n2 got src=%0d valid=%b mult_stall=%b, expected src=1 valid=1 mult_stall=0",
                     cdb_src, cdb_valid, mult_stall);
        end
        tick();
    endtask

    task automatic test_lru();
        apply_reset();
        for (int rep = 0; rep < 2; rep++) begin
            drive(2'd0, 6'd10, 32'h1010 + rep);
            drive(2'd3, 6'd11, 32'h1111 + rep);
            sb.push_back('{tag: 6'd10, data: 32'h1010 + rep, src: 2'd0});
            sb.push_back('{tag: 6'd11, data: 32'h1111 + rep, src: 2'd3});
            tick();
            idle_inputs();
            checks++;
            if (cdb_src !== 2'd0 || mem_stall !== 1'b1) begin
                errors++;
                $display("FAIL lru_first rep=%0d got src=%0d mem_stall=%b, expected src=0 mem_stall=1",
                         rep, cdb_src, mem_stall);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_all_four();
        apply_reset();
        drive(2'd0, 6'd1, 32'hA1);
        drive(2'd1, 6'd2, 32'hA2);
        drive(2'd2, 6'd3, 32'hA3);
        drive(2'd3, 6'd4, 32'hA4);
        sb.push_back('{tag: 6'd3, data: 32'hA3, src: 2'd2});
        sb.push_back('{tag: 6'd2, data: 32'hA2, src: 2'd1});
        sb.push_back('{tag: 6'd1, data: 32'hA1, src: 2'd0});
        sb.push_back('{tag: 6'd4, data: 32'hA4, src: 2'd3});
        tick();
        idle_inputs();
        checks++;
        if ({int_stall, mult_stall, div_stall, mem_stall} !== 4'b1101) begin
            errors++;
            $display("FAIL all4_stalls got int/mult/div/mem=%b%b%b%b, expected 1101",
                     int_stall, mult_stall, div_stall, mem_stall);
        end
        tick();
        tick();
        tick();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd3) begin
            errors++;
            $display("FAIL all4_mem_latency got valid=%b src=%0d, expected valid=1 src=3", cdb_valid, cdb_src);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0 || {int_stall, mult_stall, div_stall, mem_stall} !== 4'b0000) begin
            errors++;
            $display("FAIL all4_drain got valid=%b stalls=%b%b%b%b, expected valid=0 stalls=0000",
                     cdb_valid, int_stall, mult_stall, div_stall, mem_stall);
        end
`ifdef CDB_CONFLICT_CNT_EN
        checks++;
        if (conflict_cnt !== 16'd3) begin
            errors++;
            $display("FAIL all4_conflict_cnt got %0d, expected 3", conflict_cnt);
        end
`endif
    endtask

    task automatic test_overrun();
        drive(2'd2, 6'd5, 32'h55);
        drive(2'd1, 6'd6, 32'h66);
        sb.push_back('{tag: 6'd5, data: 32'h55, src: 2'd2});
        sb.push_back('{tag: 6'd6, data: 32'h66, src: 2'd1});
        tick();
        idle_inputs();
        checks++;
        if (mult_stall !== 1'b1 || cdb_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_setup got mult_stall=%b ovr=%b, expected mult_stall=1 ovr=0", mult_stall, cdb_overrun);
        end
        drive(2'd1, 6'd7, 32'h77);
        tick();
        idle_inputs();
        checks++;
        if (cdb_overrun !== 1'b1 || mult_stall !== 1'b0) begin
            errors++;
            $display("FAIL ovr_flag got ovr=%b mult_stall=%b, expected ovr=1 mult_stall=0", cdb_overrun, mult_stall);
        end
        tick();
        flush = 1;
        tick();
        flush = 0;
        tick();
        checks++;
        if (cdb_overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky_flush got %b, expected 1", cdb_overrun);
        end
        apply_reset();
        checks++;
        if (cdb_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_rst_clear got %b, expected 0", cdb_overrun);
        end
    endtask

    task automatic test_flush();
        drive(2'd0, 6'd21, 32'hB1);
        drive(2'd1, 6'd22, 32'hB2);
        drive(2'd2, 6'd23, 32'hB3);
        drive(2'd3, 6'd24, 32'hB4);
        sb.push_back('{tag: 6'd23, data: 32'hB3, src: 2'd2});
        tick();
        idle_inputs();
        flush = 1;
        tick();
        flush = 0;
        checks++;
        if (cdb_valid !== 1'b0 || {int_stall, mult_stall, div_stall, mem_stall} !== 4'b0000) begin
            errors++;
            $display("FAIL flush_clear got valid=%b stalls=%b%b%b%b, expected valid=0 stalls=0000",
                     cdb_valid, int_stall, mult_stall, div_stall, mem_stall);
        end
        // Live input during flush is discarded.
        drive(2'd0, 6'd25, 32'hB5);
        flush = 1;
        tick();
        idle_inputs();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard got valid=%b, expected 0", cdb_valid);
        end
        // int win drops lru to 0; flush must restore it so int wins the next pair.
        drive(2'd0, 6'd26, 32'hC1);
        drive(2'd3, 6'd27, 32'hC2);
        sb.push_back('{tag: 6'd26, data: 32'hC1, src: 2'd0});
        tick();
        idle_inputs();
        flush = 1;
        tick();
        flush = 0;
        drive(2'd0, 6'd28, 32'hC3);
        drive(2'd3, 6'd29, 32'hC4);
        sb.push_back('{tag: 6'd28, data: 32'hC3, src: 2'd0});
        sb.push_back('{tag: 6'd29, data: 32'hC4, src: 2'd3});
        tick();
        idle_inputs();
        checks++;
        if (cdb_src !== 2'd0 || cdb_tag !== 6'd28) begin
            errors++;
            $display("FAIL flush_lru got src=%0d tag=%0d, expected src=0 tag=28", cdb_src, cdb_tag);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_midop();
        drive(2'd0, 6'd31, 32'hD1);
        drive(2'd1, 6'd32, 32'hD2);
        drive(2'd2, 6'd33, 32'hD3);
        drive(2'd3, 6'd34, 32'hD4);
        sb.push_back('{tag: 6'd33, data: 32'hD3, src: 2'd2});
        tick();
        idle_inputs();
        @(negedge clk);
        #1;
        rst = 1;
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || {int_stall, mult_stall, div_stall, mem_stall} !== 4'b0000 || cdb_tag !== 6'd0) begin
            errors++;
            $display("FAIL async_reset got valid=%b tag=%0d stalls=%b%b%b%b, expected valid=0 tag=0 stalls=0000",
                     cdb_valid, cdb_tag, int_stall, mult_stall, div_stall, mem_stall);
        end
        tick();
        rst = 0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1;
        int_tag = '0; mult_tag = '0; div_tag = '0; mem_tag = '0;
        int_data = '0; mult_data = '0; div_data = '0; mem_data = '0;
        idle_inputs();
        test_reset();
        test_single();
        test_div_mult();
        test_lru();
        test_all_four();
        test_overrun();
        test_flush();
        test_reset_midop();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained got %0d pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
